register_port_arbiter: RTL and testbench
========================================

Name: register_port_arbiter

Overview:
- Shares the single user-side register access port of the AXI-Lite slave register file among several processing cores (filters, statistics, DMA control).
- Accepts read/write requests from NUMBER_OF_REQUESTERS clients and grants them round-robin.
- Sequences each granted request on the port as: operation cycle, capture, complete.
- Returns the read data or a write acknowledgement to the originating client.

Parameters:
- NUMBER_OF_REQUESTERS, 4: number of client ports (2..8).
- NUMBER_OF_REGISTERS, 6: valid register indices are 0..NUMBER_OF_REGISTERS-1.
- REG_DATA_WIDTH, 32: register data width.

Ports:
- S_AXI_ACLK  in  1  clock; all logic rising-edge.
- S_AXI_ARESETN  in  1  synchronous, active-low reset.
- req_valid  in  N  per-client request valid; held until accepted.
- req_write  in  N  per-client: 1 = write, 0 = read.
- req_number  in  8*N  per-client register index; client i uses bits [8i+7:8i].
- req_wdata  in  REG_DATA_WIDTH*N  per-client write data, sliced like req_number.
- req_ready  out  N  one-hot acceptance; transfer occurs when req_valid[i] & req_ready[i].
- rsp_valid  out  N  one-hot, one-cycle response pulse to the originating client.
- rsp_error  out  1  qualifies rsp_valid; 1 = index out of range.
- rsp_rdata  out  REG_DATA_WIDTH  read data; qualified by rsp_valid.
- register_operation  out  2  to slave: 0 idle, 1 read, 2 write, 3 complete.
- register_number  out  8  to slave: register index.
- register_write  out  REG_DATA_WIDTH  to slave: write data.
- register_read  in  REG_DATA_WIDTH  from slave: valid the cycle after a read operation is presented.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (S_AXI_ARESETN low at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0, including register_operation = 0 and register_number = 0.
  - Round-robin pointer goes to N-1, so client 0 has first priority.
- FSM states: IDLE, ISSUE, CAPTURE, COMPLETE, RESPOND.
- IDLE:
  - req_ready is combinational. It is asserted only for the winner g: the first requesting client at or after pointer+1 (mod N).
  - On the handshake edge, latch write, number and wdata of client g and record g.
  - If the latched number ≥ NUMBER_OF_REGISTERS, go to RESPOND with error set; the slave is never driven. Otherwise go to ISSUE.
  - With no req_valid asserted, remain in IDLE.
- ISSUE (1 cycle): register_operation = 2 for a write, 1 for a read; register_number and register_write are driven from the latched values. Next state: CAPTURE.
- CAPTURE (1 cycle): register_operation = 0. For a read, latch register_read; for a write, latched rdata = 0. Next state: COMPLETE.
- COMPLETE (1 cycle): register_operation = 3 and register_number is held. Next state: RESPOND.
- RESPOND (1 cycle):
  - rsp_valid[g] = 1, with rsp_rdata and rsp_error.
  - Pointer is set to g.
  - Next state: IDLE.
  - rsp_rdata = 0 whenever rsp_error = 1.
- register_number and register_write hold their last values outside ISSUE/COMPLETE. register_operation is 0 in every state except ISSUE and COMPLETE.
- Latency from the handshake edge T: operation at T+1, capture at T+2, complete at T+3, rsp_valid at T+4. An error response comes at T+1.
- Throughput: at most one transaction every 5 cycles (every 2 on error).
- Only one transaction is outstanding at a time. req_ready stays 0 in all non-IDLE states.
- A client still holding req_valid after its rsp_valid issues a new request. It is re-arbitrated fairly: it is granted after all other waiting clients.
- A client that deasserts req_valid before being granted is simply skipped; no response is produced.
- Reset mid-transaction abandons the transaction:
  - No rsp_valid is produced.
  - register_operation is 0 from the next edge.
  - No complete (3) is sent.
- Width rule: req_number is compared unsigned against NUMBER_OF_REGISTERS in its full 8 bits.

Test Plan:
- Client 1 writes 0xDEADBEEF to reg 2 → req_ready[1] at T. At T+1 op=2, number=2, write=0xDEADBEEF. At T+3 op=3. At T+4 rsp_valid[1]=1, rsp_error=0, rsp_rdata=0.
- Client 0 reads reg 4; slave model returns 0x12345678 one cycle after op=1 → op=1 at T+1. rsp_valid[0] at T+4 with rsp_rdata=0x12345678.
- Clients 0..3 all request continuously from reset → grant order 0,1,2,3,0. Handshakes are 5 cycles apart; each rsp_valid goes only to the matching client.
- Client 2 reads reg 6 (NUMBER_OF_REGISTERS=6) → register_operation stays 0. rsp_valid[2] with rsp_error=1 and rsp_rdata=0 one cycle after the handshake.
- Reset asserted during CAPTURE of a client 3 read → no rsp_valid. op=0 and busy=0 next cycle; client 0 wins the next arbitration.
- Clients 1 and 3 request, with client 1 re-requesting after each response → order 1,3,1,3; client 1 is never granted twice in a row while 3 waits.

Source files
------------

// File: rtl/register_port_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : register_port_arbiter_if
// Purpose  : Client request/response bundle plus the user-side register port
//            of the AXI-Lite slave register file, shared by the arbiter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface register_port_arbiter_if #(
  parameter int NUMBER_OF_REQUESTERS = 4,
  parameter int REG_DATA_WIDTH       = 32
);
  // client side
  logic [NUMBER_OF_REQUESTERS-1:0]                req_valid;
  logic [NUMBER_OF_REQUESTERS-1:0]                req_write;
  logic [8*NUMBER_OF_REQUESTERS-1:0]              req_number;
  logic [REG_DATA_WIDTH*NUMBER_OF_REQUESTERS-1:0] req_wdata;
  logic [NUMBER_OF_REQUESTERS-1:0]                req_ready;
  logic [NUMBER_OF_REQUESTERS-1:0]                rsp_valid;
  logic                                           rsp_error;
  logic [REG_DATA_WIDTH-1:0]                      rsp_rdata;
  // register file side
  logic [1:0]                                     register_operation;
  logic [7:0]                                     register_number;
  logic [REG_DATA_WIDTH-1:0]                      register_write;
  logic [REG_DATA_WIDTH-1:0]                      register_read;
  logic                                           busy;

  // arbiter view
  modport slave (
    input  req_valid, req_write, req_number, req_wdata, register_read,
    output req_ready, rsp_valid, rsp_error, rsp_rdata,
           register_operation, register_number, register_write, busy
  );

  // environment view (clients plus register file)
  modport master (
    output req_valid, req_write, req_number, req_wdata, register_read,
    input  req_ready, rsp_valid, rsp_error, rsp_rdata,
           register_operation, register_number, register_write, busy
  );
endinterface
`default_nettype wire

// File: rtl/register_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : register_port_arbiter
// Purpose  : Round-robin arbiter sharing the single register-file user port
//            among several clients; one transaction in flight at a time,
//            sequenced as operation, capture, complete, respond.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module register_port_arbiter #(
  parameter int NUMBER_OF_REQUESTERS = 4,
  parameter int NUMBER_OF_REGISTERS  = 6,
  parameter int REG_DATA_WIDTH       = 32
) (
  input  wire logic                    S_AXI_ACLK,
  input  wire logic                    S_AXI_ARESETN,
  register_port_arbiter_if.slave       bus
);

  localparam int       c_idx_w    = $clog2(NUMBER_OF_REQUESTERS);
  localparam int       c_dw       = REG_DATA_WIDTH;
  // 9 bits so the full 8-bit index compares unsigned even for 256 registers
  localparam logic [8:0] c_num_regs = 9'(NUMBER_OF_REGISTERS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    CAPTURE  = 3'd2,
    COMPLETE = 3'd3,
    RESPOND  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [c_idx_w-1:0]   ptr_q, ptr_d;
  logic [c_idx_w-1:0]   gnt_q, gnt_d;
  logic                 write_q, write_d;
  logic                 error_q, error_d;
  logic [c_dw-1:0]      rdata_q, rdata_d;
  logic [7:0]           reg_num_q, reg_num_d;
  logic [c_dw-1:0]      reg_wr_q, reg_wr_d;

  logic                 win_found;
  logic [c_idx_w-1:0]   win_idx;
  logic [7:0]           win_number;
  logic [NUMBER_OF_REQUESTERS-1:0] req_ready;
  logic [NUMBER_OF_REQUESTERS-1:0] rsp_valid;
  logic                 rsp_error;
  logic [c_dw-1:0]      rsp_rdata;
  logic [1:0]           reg_op;

  // Round-robin search: first requester strictly after the last grant
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NUMBER_OF_REQUESTERS; k++) begin
      idx = (int'(ptr_q) + k) % NUMBER_OF_REQUESTERS;
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = c_idx_w'(idx);
      end
    end
  end

  assign win_number = bus.req_number[int'(win_idx)*8 +: 8];

  // Transaction sequencer: next state, latched request fields and outputs
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    write_d   = write_q;
    error_d   = error_q;
    rdata_d   = rdata_q;
    reg_num_d = reg_num_q;
    reg_wr_d  = reg_wr_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_error = 1'b0;
    rsp_rdata = '0;
    reg_op    = 2'd0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          gnt_d   = win_idx;
          write_d = bus.req_write[win_idx];
          if ({1'b0, win_number} >= c_num_regs) begin
            // out-of-range index: answer directly, slave port untouched
            error_d = 1'b1;
            rdata_d = '0;
            state_d = RESPOND;
          end else begin
            error_d   = 1'b0;
            reg_num_d = win_number;
            reg_wr_d  = bus.req_wdata[int'(win_idx)*c_dw +: c_dw];
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        reg_op  = write_q ? 2'd2 : 2'd1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // slave read data is valid one cycle after the read operation
        rdata_d = write_q ? '0 : bus.register_read;
        state_d = COMPLETE;
      end
      COMPLETE: begin
        reg_op  = 2'd3;
        state_d = RESPOND;
      end
      RESPOND: begin
        rsp_valid[gnt_q] = 1'b1;
        rsp_error        = error_q;
        rsp_rdata        = error_q ? '0 : rdata_q;
        ptr_d            = gnt_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= IDLE;
      ptr_q     <= c_idx_w'(NUMBER_OF_REQUESTERS - 1);
      gnt_q     <= '0;
      write_q   <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
      reg_num_q <= '0;
      reg_wr_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      write_q   <= write_d;
      error_q   <= error_d;
      rdata_q   <= rdata_d;
      reg_num_q <= reg_num_d;
      reg_wr_q  <= reg_wr_d;
    end
  end

  assign bus.req_ready          = req_ready;
  assign bus.rsp_valid          = rsp_valid;
  assign bus.rsp_error          = rsp_error;
  assign bus.rsp_rdata          = rsp_rdata;
  assign bus.register_operation = reg_op;
  assign bus.register_number    = reg_num_q;
  assign bus.register_write     = reg_wr_q;
  assign bus.busy               = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_register_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_register_port_arbiter
// Purpose  : Directed self-checking bench for register_port_arbiter with a
//            small register-file slave model on the user port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_register_port_arbiter;

  localparam int c_n  = 4;
  localparam int c_dw = 32;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  logic [c_dw-1:0] mem [0:5];

  register_port_arbiter_if #(
    .NUMBER_OF_REQUESTERS(c_n),
    .REG_DATA_WIDTH      (c_dw)
  ) bus ();

  register_port_arbiter #(
    .NUMBER_OF_REQUESTERS(c_n),
    .NUMBER_OF_REGISTERS (6),
    .REG_DATA_WIDTH      (c_dw)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rstn),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file slave model: read data one cycle after op=1, writes on op=2
  always @(posedge clk) begin
    if (!rstn) begin
      mem[0] <= 32'hA0A0_0000;
      mem[1] <= 32'hA1A1_0001;
      mem[2] <= 32'hA2A2_0002;
      mem[3] <= 32'hA3A3_0003;
      mem[4] <= 32'h1234_5678;
      mem[5] <= 32'hA5A5_0005;
      bus.register_read <= '0;
    end else begin
      if (bus.register_operation == 2'd1 && bus.register_number < 8'd6)
        bus.register_read <= mem[bus.register_number[2:0]];
      else
        bus.register_read <= 32'hFFFF_FFFF;
      if (bus.register_operation == 2'd2 && bus.register_number < 8'd6)
        mem[bus.register_number[2:0]] <= bus.register_write;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic w, input logic [7:0] num,
                         input logic [31:0] wd);
    bus.req_write[c]           = w;
    bus.req_number[c*8 +: 8]   = num;
    bus.req_wdata[c*c_dw +: c_dw] = wd;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  // Runs one full read transaction of a held request and checks its grant
  task automatic run_read(input string tag, input int g, input logic [31:0] exp_rdata);
    check({tag, " ready"}, 32'(bus.req_ready), 32'(1 << g));
    tick();
    check({tag, " op"}, 32'(bus.register_operation), 32'd1);
    check({tag, " num"}, 32'(bus.register_number), 32'(g));
    tick();
    tick();
    tick();
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(1 << g));
    check({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
    tick();
  endtask

  initial begin
    logic [31:0] t3_exp [0:4];
    int          t6_ord [0:3];
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b0;
    bus.req_valid  = '0;
    bus.req_write  = '0;
    bus.req_number = '0;
    bus.req_wdata  = '0;
    tick();
    tick();
    // reset state
    check("rst op",   32'(bus.register_operation), 32'd0);
    check("rst num",  32'(bus.register_number), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst rsp",  32'(bus.rsp_valid), 32'd0);
    rstn = 1'b1;
    tick();

    // Test 1: client 1 writes 0xDEADBEEF to reg 2
    set_req(1, 1'b1, 8'd2, 32'hDEAD_BEEF);
    bus.req_valid = 4'b0010;
    #1;
    check("t1 ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    check("t1 op issue", 32'(bus.register_operation), 32'd2);
    check("t1 num",      32'(bus.register_number), 32'd2);
    check("t1 wdata",    bus.register_write, 32'hDEAD_BEEF);
    check("t1 busy",     32'(bus.busy), 32'd1);
    tick();
    check("t1 op capture", 32'(bus.register_operation), 32'd0);
    tick();
    check("t1 op complete", 32'(bus.register_operation), 32'd3);
    check("t1 num held",    32'(bus.register_number), 32'd2);
    tick();
    check("t1 rsp_valid", 32'(bus.rsp_valid), 32'h2);
    check("t1 rsp_error", 32'(bus.rsp_error), 32'd0);
    check("t1 rsp_rdata", bus.rsp_rdata, 32'd0);
    check("t1 mem[2]",    mem[2], 32'hDEAD_BEEF);
    tick();
    check("t1 idle rsp",  32'(bus.rsp_valid), 32'd0);
    check("t1 idle busy", 32'(bus.busy), 32'd0);

    // Test 2: client 0 reads reg 4
    set_req(0, 1'b0, 8'd4, 32'd0);
    bus.req_valid = 4'b0001;
    #1;
    check("t2 ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    check("t2 op", 32'(bus.register_operation), 32'd1);
    check("t2 num", 32'(bus.register_number), 32'd4);
    tick();
    tick();
    tick();
    check("t2 rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t2 rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    check("t2 rsp_error", 32'(bus.rsp_error), 32'd0);
    tick();

    // Test 3: all clients request continuously from reset, each reads reg = own index
    t3_exp[0] = 32'hA0A0_0000;
    t3_exp[1] = 32'hA1A1_0001;
    t3_exp[2] = 32'hA2A2_0002;
    t3_exp[3] = 32'hA3A3_0003;
    t3_exp[4] = 32'hA0A0_0000;
    for (int c = 0; c < c_n; c++) set_req(c, 1'b0, 8'(c), 32'd0);
    bus.req_valid = 4'b1111;
    do_reset();
    for (int i = 0; i < 5; i++) run_read($sformatf("t3 g%0d", i), i % c_n, t3_exp[i]);
    bus.req_valid = '0;

    // Test 4: client 2 reads out-of-range reg 6
    set_req(2, 1'b0, 8'd6, 32'd0);
    bus.req_valid = 4'b0100;
    #1;
    check("t4 ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    check("t4 rsp_valid", 32'(bus.rsp_valid), 32'h4);
    check("t4 rsp_error", 32'(bus.rsp_error), 32'd1);
    check("t4 rsp_rdata", bus.rsp_rdata, 32'd0);
    check("t4 op",        32'(bus.register_operation), 32'd0);
    check("t4 num",       32'(bus.register_number), 32'd0);
    tick();
    check("t4 idle rsp", 32'(bus.rsp_valid), 32'd0);
    check("t4 idle op",  32'(bus.register_operation), 32'd0);

    // Test 5: reset during CAPTURE of a client 3 read
    set_req(3, 1'b0, 8'd3, 32'd0);
    bus.req_valid = 4'b1000;
    #1;
    check("t5 ready", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = '0;
    check("t5 op issue", 32'(bus.register_operation), 32'd1);
    tick();
    rstn = 1'b0;
    tick();
    check("t5 op after rst",   32'(bus.register_operation), 32'd0);
    check("t5 busy after rst", 32'(bus.busy), 32'd0);
    check("t5 rsp after rst",  32'(bus.rsp_valid), 32'd0);
    rstn = 1'b1;
    set_req(0, 1'b0, 8'd5, 32'd0);
    bus.req_valid = 4'b1001;
    #1;
    check("t5 ready after rst", 32'(bus.req_ready), 32'h1);
    tick();
    check("t5 num", 32'(bus.register_number), 32'd5);
    tick();
    check("t5 no rsp", 32'(bus.rsp_valid), 32'd0);
    tick();
    tick();
    check("t5 rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t5 rsp_rdata", bus.rsp_rdata, 32'hA5A5_0005);
    check("t5 ready resp", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    tick();

    // Test 6: clients 1 and 3 held, fair alternation 1,3,1,3
    t6_ord[0] = 1;
    t6_ord[1] = 3;
    t6_ord[2] = 1;
    t6_ord[3] = 3;
    set_req(1, 1'b0, 8'd1, 32'd0);
    set_req(3, 1'b0, 8'd3, 32'd0);
    bus.req_valid = 4'b1010;
    do_reset();
    for (int i = 0; i < 4; i++)
      run_read($sformatf("t6 g%0d", i), t6_ord[i],
               (t6_ord[i] == 1) ? 32'hA1A1_0001 : 32'hA3A3_0003);
    bus.req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
